// File: rtl/pet_mem_pkg.sv
// Shared types for the PET core SDRAM port arbitration: client indices,
// arbiter FSM states and the read word returned on a watchdog abort.
package pet_mem_pkg;

    typedef enum logic [1:0] {
        CLI_CHAR = 2'd0,
        CLI_ROM  = 2'd1,
        CLI_TAPE = 2'd2
    } client_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } arb_state_e;

    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/sdram_port_prio.sv
// Combinational priority picker: char > rom > tape, with tape forced
// first once the starvation guard trips.
module sdram_port_prio
    import pet_mem_pkg::*;
(
    input  logic [2:0] pending,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (starve && pending[CLI_TAPE])
            grant[CLI_TAPE] = 1'b1;
        else if (pending[CLI_CHAR])
            grant[CLI_CHAR] = 1'b1;
        else if (pending[CLI_ROM])
            grant[CLI_ROM] = 1'b1;
        else if (pending[CLI_TAPE])
            grant[CLI_TAPE] = 1'b1;
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Serialises the char, rom and tape toggle-handshake clients onto one
// level-held SDRAM command port, with tape anti-starvation and a watchdog.
module sdram_port_arb
    import pet_mem_pkg::*;
#(
    parameter int AW         = 25,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 255
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          init_done,

    input  logic          char_req,
    input  logic [AW-1:0] char_addr,
    input  logic          char_we,
    input  logic [7:0]    char_din,
    output logic          char_ack,
    output logic [15:0]   char_dout,

    input  logic          rom_req,
    input  logic [AW-1:0] rom_addr,
    input  logic          rom_we,
    input  logic [7:0]    rom_din,
    output logic          rom_ack,
    output logic [15:0]   rom_dout,

    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,
    input  logic          tape_we,
    input  logic [7:0]    tape_din,
    output logic          tape_ack,
    output logic [15:0]   tape_dout,

    output logic          mem_req,
    output logic [AW-2:0] mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_wdata,
    input  logic          mem_done,
    input  logic [15:0]   mem_rdata,

    output logic          busy,
    output logic          timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_e        state;
    client_e           winner;
    logic [2:0]        req_raw;
    logic [2:0]        req_q;
    logic [2:0]        ack_r;
    logic [2:0][15:0]  dout_r;
    logic [2:0]        pending;
    logic [2:0]        grant;
    logic              starve;
    logic [SW-1:0]     starve_cnt;
    logic [WW-1:0]     watchdog;

    logic [AW-1:0]     sel_addr;
    logic              sel_we;
    logic [7:0]        sel_din;
    client_e           sel_cli;

    assign req_raw   = {tape_req, rom_req, char_req};
    assign pending   = req_q ^ ack_r;
    assign starve    = (starve_cnt == SW'(STARVE_MAX));

    assign char_ack  = ack_r[CLI_CHAR];
    assign rom_ack   = ack_r[CLI_ROM];
    assign tape_ack  = ack_r[CLI_TAPE];
    assign char_dout = dout_r[CLI_CHAR];
    assign rom_dout  = dout_r[CLI_ROM];
    assign tape_dout = dout_r[CLI_TAPE];

    sdram_port_prio u_prio (
        .pending (pending),
        .starve  (starve),
        .grant   (grant)
    );

    always_comb begin
        sel_addr = char_addr;
        sel_we   = char_we;
        sel_din  = char_din;
        sel_cli  = CLI_CHAR;
        if (grant[CLI_TAPE]) begin
            sel_addr = tape_addr;
            sel_we   = tape_we;
            sel_din  = tape_din;
            sel_cli  = CLI_TAPE;
        end else if (grant[CLI_ROM]) begin
            sel_addr = rom_addr;
            sel_we   = rom_we;
            sel_din  = rom_din;
            sel_cli  = CLI_ROM;
        end
    end

    // Acks are preloaded from the live requests so a client whose req is
    // already high at reset is not seen as pending afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= req_raw;
            ack_r       <= req_raw;
            dout_r      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_be      <= 2'b00;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            starve_cnt  <= '0;
            watchdog    <= '0;
            winner      <= CLI_CHAR;
            state       <= ST_IDLE;
        end else begin
            req_q <= req_raw;
            case (state)
                ST_IDLE: begin
                    if (!pending[CLI_TAPE])
                        starve_cnt <= '0;
                    if (init_done && (|pending)) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= sel_addr[AW-1:1];
                        mem_we    <= sel_we;
                        mem_be    <= sel_addr[0] ? 2'b01 : 2'b10;
                        mem_wdata <= {sel_din, sel_din};
                        winner    <= sel_cli;
                        watchdog  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                        if (grant[CLI_TAPE])
                            starve_cnt <= '0;
                        else if (pending[CLI_TAPE] && !starve)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end

                // A completion in the same cycle as the deadline still wins.
                ST_ACCESS: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            dout_r[winner] <= mem_rdata;
                        state <= ST_FINISH;
                    end else if (watchdog == WW'(TIMEOUT - 1)) begin
                        mem_req        <= 1'b0;
                        dout_r[winner] <= TIMEOUT_RDATA;
                        timeout_err    <= 1'b1;
                        state          <= ST_FINISH;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end

                ST_FINISH: begin
                    ack_r[winner] <= ~ack_r[winner];
                    watchdog      <= '0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end

                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: latency, priority, starvation,
// writes, watchdog abort, reset mid-access and init_done gating.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        reset, init_done;
    logic        char_req, char_we, rom_req, rom_we, tape_req, tape_we;
    logic [24:0] char_addr, rom_addr, tape_addr;
    logic [7:0]  char_din, rom_din, tape_din;
    logic        char_ack, rom_ack, tape_ack;
    logic [15:0] char_dout, rom_dout, tape_dout;
    logic        mem_req, mem_we, mem_done, busy, timeout_err;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_tape;

    always #5 clk = ~clk;

    sdram_port_arb #(.AW(25), .STARVE_MAX(8), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .char_req(char_req), .char_addr(char_addr), .char_we(char_we),
        .char_din(char_din), .char_ack(char_ack), .char_dout(char_dout),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_we(rom_we),
        .rom_din(rom_din), .rom_ack(rom_ack), .rom_dout(rom_dout),
        .tape_req(tape_req), .tape_addr(tape_addr), .tape_we(tape_we),
        .tape_din(tape_din), .tape_ack(tape_ack), .tape_dout(tape_dout),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // One-cycle done strobe, then step past the ack edge.
    task automatic serve(input logic [15:0] d);
        mem_done  = 1'b1;
        mem_rdata = d;
        tick();
        mem_done  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({char_ack, rom_ack, tape_ack, mem_req, mem_we, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {char_ack, rom_ack, tape_ack, mem_req, mem_we, busy, timeout_err});
        end
        checks++;
        if ({char_dout, rom_dout, tape_dout, mem_wdata, mem_addr, mem_be} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h %h %h %h %h %h expected all zero",
                     char_dout, rom_dout, tape_dout, mem_wdata, mem_addr, mem_be);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rom_read();
        rom_addr = 25'h3001;
        rom_we   = 1'b0;
        rom_req  = ~rom_req;
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rom_latency1: got mem_req=%b expected 0", mem_req);
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be, busy} !== 5'b1_0_01_1 || mem_addr !== 24'h001800) begin
            errors++;
            $display("[TB] FAIL rom_cmd: got req=%b we=%b be=%b busy=%b addr=%h expected 1 0 01 1 001800",
                     mem_req, mem_we, mem_be, busy, mem_addr);
        end
        tick();
        tick();
        mem_done  = 1'b1;
        mem_rdata = 16'hA55A;
        tick();
        mem_done  = 1'b0;
        checks++;
        if (rom_dout !== 16'hA55A || rom_ack !== ~rom_req || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rom_data: got dout=%h ack=%b req=%b expected A55A %b 0",
                     rom_dout, rom_ack, mem_req, ~rom_req);
        end
        tick();
        checks++;
        if (rom_ack !== rom_req || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rom_ack: got ack=%b busy=%b expected %b 0", rom_ack, busy, rom_req);
        end
    endtask

    task automatic test_priority();
        bit ok;
        char_addr = 25'h100; rom_addr = 25'h201; tape_addr = 25'h302;
        char_we = 1'b0; rom_we = 1'b0; tape_we = 1'b0;
        char_req = ~char_req; rom_req = ~rom_req; tape_req = ~tape_req;

        wait_req(10, ok);
        checks++;
        if (!ok || mem_addr !== 24'h000080) begin
            errors++;
            $display("[TB] FAIL prio_first: got ok=%b addr=%h expected 1 000080", ok, mem_addr);
        end
        serve(16'h1111);
        checks++;
        if (char_dout !== 16'h1111 || rom_dout !== 16'hA55A || tape_dout !== 16'h0000 ||
            char_ack !== char_req || rom_ack === rom_req || tape_ack === tape_req) begin
            errors++;
            $display("[TB] FAIL prio_char_done: got %h %h %h acks=%b%b%b expected 1111 A55A 0000 only char acked",
                     char_dout, rom_dout, tape_dout, char_ack, rom_ack, tape_ack);
        end

        wait_req(10, ok);
        checks++;
        if (!ok || mem_addr !== 24'h000100) begin
            errors++;
            $display("[TB] FAIL prio_second: got ok=%b addr=%h expected 1 000100", ok, mem_addr);
        end
        serve(16'h2222);
        checks++;
        if (rom_dout !== 16'h2222 || char_dout !== 16'h1111 || tape_dout !== 16'h0000 ||
            rom_ack !== rom_req || tape_ack === tape_req) begin
            errors++;
            $display("[TB] FAIL prio_rom_done: got %h %h %h expected 2222 1111 0000",
                     rom_dout, char_dout, tape_dout);
        end

        wait_req(10, ok);
        checks++;
        if (!ok || mem_addr !== 24'h000181) begin
            errors++;
            $display("[TB] FAIL prio_third: got ok=%b addr=%h expected 1 000181", ok, mem_addr);
        end
        serve(16'h3333);
        checks++;
        if (tape_dout !== 16'h3333 || tape_ack !== tape_req || rom_dout !== 16'h2222) begin
            errors++;
            $display("[TB] FAIL prio_tape_done: got tape=%h ack=%b rom=%h expected 3333 %b 2222",
                     tape_dout, tape_ack, rom_dout, tape_req);
        end
    endtask

    task automatic test_starvation();
        bit ok;
        bit tape_seen;
        int n_cr;
        logic [15:0] val;
        tape_seen = 1'b0;
        n_cr = 0;
        char_req = ~char_req; rom_req = ~rom_req; tape_req = ~tape_req;
        for (int g = 0; g < 12 && !tape_seen; g++) begin
            wait_req(20, ok);
            if (!ok) begin
                errors++;
                checks++;
                $display("[TB] FAIL starve_wait: got no mem_req expected one within 20 cycles");
                break;
            end
            val = 16'h5A00 + 16'(g);
            if (mem_addr == 24'h000181) begin
                tape_seen = 1'b1;
                exp_tape  = val;
                serve(val);
            end else if (mem_addr == 24'h000080) begin
                serve(val);
                char_req = ~char_req;
                n_cr++;
            end else begin
                serve(val);
                rom_req = ~rom_req;
                n_cr++;
            end
        end
        checks++;
        if (!tape_seen || n_cr != 8) begin
            errors++;
            $display("[TB] FAIL starve_count: got tape_seen=%b grants=%0d expected 1 8", tape_seen, n_cr);
        end
        for (int k = 0; k < 2; k++) begin
            wait_req(20, ok);
            if (ok) serve(16'h0F0F);
        end
        checks++;
        if (char_ack !== char_req || rom_ack !== rom_req || tape_dout !== exp_tape) begin
            errors++;
            $display("[TB] FAIL starve_drain: got acks=%b%b tape=%h expected %b%b %h",
                     char_ack, rom_ack, tape_dout, char_req, rom_req, exp_tape);
        end
    endtask

    task automatic test_write();
        bit ok;
        tape_we = 1'b1; tape_addr = 25'h10; tape_din = 8'h5C;
        tape_req = ~tape_req;
        wait_req(10, ok);
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_be !== 2'b10 || mem_wdata !== 16'h5C5C || mem_addr !== 24'h000008) begin
            errors++;
            $display("[TB] FAIL write_cmd: got ok=%b we=%b be=%b wdata=%h addr=%h expected 1 1 10 5C5C 000008",
                     ok, mem_we, mem_be, mem_wdata, mem_addr);
        end
        serve(16'hDEAD);
        checks++;
        if (tape_dout !== exp_tape || tape_ack !== tape_req) begin
            errors++;
            $display("[TB] FAIL write_done: got dout=%h ack=%b expected %h %b",
                     tape_dout, tape_ack, exp_tape, tape_req);
        end
        tape_we = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int high;
        char_addr = 25'h100; char_we = 1'b0;
        char_req = ~char_req;
        wait_req(10, ok);
        high = 0;
        while (mem_req && high < 400) begin
            high++;
            tick();
        end
        checks++;
        if (!ok || high != 255) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d cycles expected 255", high);
        end
        checks++;
        if (char_dout !== 16'hFFFF || timeout_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got dout=%h err=%b req=%b expected FFFF 1 0",
                     char_dout, timeout_err, mem_req);
        end
        tick();
        checks++;
        if (char_ack !== char_req) begin
            errors++;
            $display("[TB] FAIL timeout_ack: got %b expected %b", char_ack, char_req);
        end
        rom_addr = 25'h201; rom_we = 1'b0;
        rom_req = ~rom_req;
        wait_req(10, ok);
        serve(16'h7777);
        checks++;
        if (!ok || rom_dout !== 16'h7777 || rom_ack !== rom_req || timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got ok=%b dout=%h ack=%b err=%b expected 1 7777 %b 1",
                     ok, rom_dout, rom_ack, timeout_err, rom_req);
        end
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        rom_req = ~rom_req;
        wait_req(10, ok);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (!ok || mem_req !== 1'b0 || rom_ack !== rom_req || busy !== 1'b0 ||
            timeout_err !== 1'b0 || rom_dout !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got ok=%b req=%b ack=%b busy=%b err=%b dout=%h expected 1 0 %b 0 0 0000",
                     ok, mem_req, rom_ack, busy, timeout_err, rom_dout, rom_req);
        end
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_grant: got req=%b busy=%b expected 0 0", mem_req, busy);
        end
    endtask

    task automatic test_init_gate();
        bit ok;
        init_done = 1'b0;
        char_req = ~char_req;
        repeat (6) tick();
        checks++;
        if (mem_req !== 1'b0 || char_ack === char_req) begin
            errors++;
            $display("[TB] FAIL init_gate: got req=%b ack=%b expected 0 %b", mem_req, char_ack, ~char_req);
        end
        init_done = 1'b1;
        wait_req(10, ok);
        serve(16'hBEEF);
        checks++;
        if (!ok || char_dout !== 16'hBEEF || char_ack !== char_req) begin
            errors++;
            $display("[TB] FAIL init_release: got ok=%b dout=%h ack=%b expected 1 BEEF %b",
                     ok, char_dout, char_ack, char_req);
        end
        mem_done = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_done = 1'b0;
        tick();
        checks++;
        if (char_dout !== 16'hBEEF || char_ack !== char_req || busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_done: got dout=%h ack=%b busy=%b req=%b expected BEEF %b 0 0",
                     char_dout, char_ack, busy, mem_req, char_req);
        end
    endtask

    initial begin
        reset = 1'b1; init_done = 1'b1;
        char_req = 1'b0; rom_req = 1'b0; tape_req = 1'b0;
        char_we = 1'b0; rom_we = 1'b0; tape_we = 1'b0;
        char_addr = '0; rom_addr = '0; tape_addr = '0;
        char_din = 8'h00; rom_din = 8'h00; tape_din = 8'h00;
        mem_done = 1'b0; mem_rdata = 16'h0;
        exp_tape = 16'h0;
        $display("[TB] starting sdram_port_arb bench");
        test_reset();
        test_rom_read();
        test_priority();
        test_starvation();
        test_write();
        test_timeout();
        test_reset_mid_access();
        test_init_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
